// File: rtl/e_mdu_pkg.sv
// Shared MDU definitions: op encodings, default latencies and FSM state encoding.
// Used by e_mdu and by the D-stage decoder/hazard logic.
package e_mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed MULT_CYCLES/DIV_CYCLES latency, HI/LO commit as busy falls.
// No backpressure of its own; busy lets the hazard unit stall D, and ops arriving while busy are dropped.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDR
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_p, lo_p;
  logic               accept, commit;
  logic               is_mul, sgn_div;
  logic signed [63:0] a_sx, b_sx, prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        n_abs, d_abs, d_safe, q_mag, r_mag, q_res, r_res;
  logic [31:0]        res_hi, res_lo;

  assign is_mul  = (mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU);
  assign sgn_div = (mdu_op == MDU_DIV);

  assign a_sx   = {{32{A[31]}}, A};
  assign b_sx   = {{32{B[31]}}, B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide via magnitudes: quotient truncates toward zero, remainder follows the dividend.
  assign n_abs  = (sgn_div && A[31]) ? -A : A;
  assign d_abs  = (sgn_div && B[31]) ? -B : B;
  assign d_safe = (d_abs == 32'd0) ? 32'd1 : d_abs;
  assign q_mag  = n_abs / d_safe;
  assign r_mag  = n_abs % d_safe;
  assign q_res  = (sgn_div && (A[31] ^ B[31])) ? -q_mag : q_mag;
  assign r_res  = (sgn_div && A[31]) ? -r_mag : r_mag;

  always_comb begin
    res_hi = HI;
    res_lo = LO;
    case (mdu_op)
      MDU_MULT:  {res_hi, res_lo} = prod_s;
      MDU_MULTU: {res_hi, res_lo} = prod_u;
      MDU_DIV, MDU_DIVU: begin
        if (B != 32'd0) begin
          res_hi = r_res;
          res_lo = q_res;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid && (mdu_op >= MDU_MULT) && (mdu_op <= MDU_DIVU)) begin
          accept  = 1'b1;
          state_d = RUN;
          cnt_d   = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end
      end
      RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_p    <= '0;
      lo_p    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        hi_p <= res_hi;
        lo_p <= res_lo;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      HI <= '0;
      LO <= '0;
    end else if (commit) begin
      HI <= hi_p;
      LO <= lo_p;
    end else if (state_q == IDLE && valid) begin
      if (mdu_op == MDU_MTHI) HI <= A;
      if (mdu_op == MDU_MTLO) LO <= A;
    end
  end

  assign busy = (state_q == RUN);
  assign MDR  = (mdu_op == MDU_MFHI) ? HI :
                (mdu_op == MDU_MFLO) ? LO : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: reference model tracks HI/LO and the absolute cycle a result lands.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid = 1'b0;
  logic [3:0]  mdu_op = 4'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy;
  logic [31:0] HI, LO, MDR;

  int total = 0;
  int bad   = 0;

  e_mdu dut (
    .clk(clk), .reset(reset), .valid(valid), .mdu_op(mdu_op),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO), .MDR(MDR)
  );

  always #5 clk = ~clk;

  // Reference model: result lands at edge (accept_edge + latency).
  int          cyc = 0;
  int          done_at = 0;
  bit          pending = 1'b0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;

  always @(posedge clk or negedge reset) begin
    longint      sa, sb, q, r;
    logic [63:0] pr;
    if (!reset) begin
      pending = 1'b0;
      m_hi = 32'd0;
      m_lo = 32'd0;
    end else begin
      if (pending) begin
        if (cyc == done_at) begin
          m_hi = p_hi;
          m_lo = p_lo;
          pending = 1'b0;
        end
      end else if (valid) begin
        sa = longint'($signed(A));
        sb = longint'($signed(B));
        case (mdu_op)
          4'd1: begin pr = sa * sb; {p_hi, p_lo} = pr; pending = 1'b1; done_at = cyc + 5; end
          4'd2: begin pr = {32'd0, A} * {32'd0, B}; {p_hi, p_lo} = pr; pending = 1'b1; done_at = cyc + 5; end
          4'd3, 4'd4: begin
            pending = 1'b1;
            done_at = cyc + 10;
            if (B == 32'd0) begin
              p_hi = m_hi;
              p_lo = m_lo;
            end else begin
              if (mdu_op == 4'd4) begin
                sa = longint'({32'd0, A});
                sb = longint'({32'd0, B});
              end
              q = sa / sb;
              r = sa % sb;
              p_lo = q[31:0];
              p_hi = r[31:0];
            end
          end
          4'd7: m_hi = A;
          4'd8: m_lo = A;
          default: ;
        endcase
      end
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, sampled 1ns after the rising edge.
  always @(posedge clk) begin
    logic [31:0] exp_mdr;
    #1;
    exp_mdr = (mdu_op == 4'd5) ? m_hi : (mdu_op == 4'd6) ? m_lo : 32'd0;
    chk("model_busy", {31'd0, busy}, {31'd0, pending});
    chk("model_hi", HI, m_hi);
    chk("model_lo", LO, m_lo);
    chk("model_mdr", MDR, exp_mdr);
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    valid  = 1'b1;
    mdu_op = op;
    A      = a;
    B      = b;
    @(negedge clk);
    valid  = 1'b0;
    mdu_op = 4'd0;
    A      = 32'd0;
    B      = 32'd0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mdr", MDR, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    issue(4'd7, 32'h12345678, 32'd0);
    valid = 1'b1; mdu_op = 4'd5;
    #1 chk("mfhi_mdr", MDR, 32'h12345678);
    @(negedge clk);
    valid = 1'b0; mdu_op = 4'd0;

    issue(4'd1, 32'hFFFFFFFF, 32'd2);
    #1 chk("mult_busy_c1", {31'd0, busy}, 32'd1);
    wait_cyc(4);
    chk("mult_busy_c5", {31'd0, busy}, 32'd1);
    wait_cyc(1);
    chk("mult_busy_c6", {31'd0, busy}, 32'd0);
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFFE);

    issue(4'd2, 32'hFFFFFFFF, 32'd2);
    wait_cyc(5);
    chk("multu_hi", HI, 32'h00000001);
    chk("multu_lo", LO, 32'hFFFFFFFE);

    issue(4'd3, 32'hFFFFFFF9, 32'd2);
    wait_cyc(9);
    chk("div_busy_c10", {31'd0, busy}, 32'd1);
    wait_cyc(1);
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'hFFFFFFFF);

    issue(4'd7, 32'h000000AA, 32'd0);
    issue(4'd8, 32'h000000BB, 32'd0);
    issue(4'd4, 32'd7, 32'd0);
    wait_cyc(9);
    chk("div0_busy_c10", {31'd0, busy}, 32'd1);
    wait_cyc(1);
    chk("div0_hi", HI, 32'h000000AA);
    chk("div0_lo", LO, 32'h000000BB);

    issue(4'd1, 32'd3, 32'd4);
    issue(4'd1, 32'd100, 32'd100);
    issue(4'd8, 32'd5, 32'd0);
    wait_cyc(2);
    chk("ign_busy_c5", {31'd0, busy}, 32'd1);
    wait_cyc(1);
    chk("ign_hi", HI, 32'd0);
    chk("ign_lo", LO, 32'd12);

    issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_cyc(10);
    chk("ovf_lo", LO, 32'h80000000);
    chk("ovf_hi", HI, 32'd0);

    issue(4'd3, 32'd7, 32'hFFFFFFFE);
    wait_cyc(10);
    chk("divneg_lo", LO, 32'hFFFFFFFD);
    chk("divneg_hi", HI, 32'd1);

    issue(4'd1, 32'hFFFFFFFD, 32'hFFFFFFFB);
    wait_cyc(5);
    chk("multneg_hi", HI, 32'd0);
    chk("multneg_lo", LO, 32'd15);

    mdu_op = 4'd1; A = 32'd9; B = 32'd9;
    @(negedge clk);
    mdu_op = 4'd7;
    @(negedge clk);
    #1 chk("novalid_busy", {31'd0, busy}, 32'd0);
    chk("novalid_hi", HI, 32'd0);
    mdu_op = 4'd0; A = 32'd0; B = 32'd0;

    issue(4'd1, 32'd3, 32'd5);
    wait_cyc(2);
    #1 reset = 1'b0;
    #1;
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_hi", HI, 32'd0);
    chk("rstmid_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    wait_cyc(8);
    chk("rstmid_late_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_late_lo", LO, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
